mux8way16_rr: RTL

Registered 8-to-1 16-bit collector: the reverse path of the 8-way 16-bit demultiplexer. Eight producers each present a word with a valid/ready handshake; a round-robin arbiter picks one per cycle and loads it into a one-entry output register, tagged with its source index. It sits in front of any shared single-port consumer (RAM write port, bus, output register file) that the 8-way demux fans out from.

---
 rtl/mux8way16_pkg.sv | 15 +
 rtl/mux8way16_rr_if.sv | 40 ++++
 rtl/mux8way16_rr_arbiter8.sv | 30 +++
 rtl/mux8way16_rr.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mux8way16_pkg.sv
// Shared types and sizes for the 8-way 16-bit round-robin collector.
package mux8way16_pkg;

  localparam int unsigned N_WAYS         = 8;
  localparam int unsigned SEL_W          = 3;
  localparam int unsigned DATA_W_DEFAULT = 16;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mux_state_e;

endpackage

// File: rtl/mux8way16_rr_if.sv
// Producer/consumer bundle for mux8way16_rr; in_last/out_last exist only
// when MUX8WAY16_BURST_LOCK_EN is defined.
interface mux8way16_rr_if #(
  parameter int unsigned DATA_W = mux8way16_pkg::DATA_W_DEFAULT
);
  import mux8way16_pkg::*;

  logic [N_WAYS*DATA_W-1:0] in_data;
  logic [N_WAYS-1:0]        in_valid;
  logic [N_WAYS-1:0]        in_ready;
`ifdef MUX8WAY16_BURST_LOCK_EN
  logic [N_WAYS-1:0]        in_last;
  logic                     out_last;
`endif
  logic [DATA_W-1:0]        out_data;
  sel_t                     out_sel;
  logic                     out_valid;
  logic                     out_ready;

  // Producers and consumer side (bench / surrounding fabric)
  modport master (
    output in_data, in_valid,
`ifdef MUX8WAY16_BURST_LOCK_EN
    output in_last, input out_last,
`endif
    input  in_ready, out_data, out_sel, out_valid,
    output out_ready
  );

  // Collector side
  modport slave (
    input  in_data, in_valid,
`ifdef MUX8WAY16_BURST_LOCK_EN
    input  in_last, output out_last,
`endif
    output in_ready, out_data, out_sel, out_valid,
    input  out_ready
  );

endinterface

// File: rtl/mux8way16_rr_arbiter8.sv
// Combinational 8-way round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter8
  import mux8way16_pkg::*;
(
  input  logic [N_WAYS-1:0] req,
  input  sel_t              ptr,
  input  logic              en,
  output logic [N_WAYS-1:0] grant,
  output sel_t              grant_idx,
  output logic              grant_any
);

  sel_t ch;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    ch        = ptr;
    for (int k = 0; k < int'(N_WAYS); k++) begin
      ch = ptr + sel_t'(k);
      if (en && req[ch] && !grant_any) begin
        grant_any = 1'b1;
        grant_idx = ch;
        grant[ch] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8way16_rr.sv
// Registered 8-to-1 collector with round-robin arbitration and a one-entry
// output register. Define MUX8WAY16_BURST_LOCK_EN to hold a grant across bursts.
module mux8way16_rr
  import mux8way16_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  mux8way16_rr_if.slave  bus
);

  mux_state_e        state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  sel_t              out_sel_q, out_sel_d;
  sel_t              ptr_q, ptr_d;

  logic              load_c;
  logic              arb_en_c;
  logic [N_WAYS-1:0] req_c;
  logic [N_WAYS-1:0] grant_c;
  sel_t              grant_idx_c;
  logic              grant_any_c;
  logic [DATA_W-1:0] words_c [N_WAYS];

`ifdef MUX8WAY16_BURST_LOCK_EN
  logic lock_q, lock_d;
  logic out_last_q, out_last_d;
  logic word_last_c;

  // While locked only the channel that opened the burst may compete.
  assign req_c       = lock_q ? (bus.in_valid & (N_WAYS'(1) << out_sel_q)) : bus.in_valid;
  assign word_last_c = bus.in_last[grant_idx_c];
`else
  assign req_c = bus.in_valid;
`endif

  // No grant may be offered while reset is held.
  assign arb_en_c = load_c && !rst;

  rr_arbiter8 u_arb (
    .req       (req_c),
    .ptr       (ptr_q),
    .en        (arb_en_c),
    .grant     (grant_c),
    .grant_idx (grant_idx_c),
    .grant_any (grant_any_c)
  );

  always_comb begin
    for (int i = 0; i < int'(N_WAYS); i++) begin
      words_c[i] = bus.in_data[i*int'(DATA_W) +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a grant implies a transfer because grants need load=1
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (grant_any_c) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready && !grant_any_c) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    load_c     = (state_q == ST_EMPTY) || bus.out_ready;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    ptr_d      = ptr_q;
`ifdef MUX8WAY16_BURST_LOCK_EN
    lock_d     = lock_q;
    out_last_d = out_last_q;
`endif
    if (grant_any_c) begin
      out_data_d = words_c[grant_idx_c];
      out_sel_d  = grant_idx_c;
`ifdef MUX8WAY16_BURST_LOCK_EN
      out_last_d = word_last_c;
      lock_d     = !word_last_c;
      if (word_last_c) ptr_d = grant_idx_c + sel_t'(1);
`else
      ptr_d      = grant_idx_c + sel_t'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q <= '0;
      out_sel_q  <= '0;
      ptr_q      <= '0;
`ifdef MUX8WAY16_BURST_LOCK_EN
      lock_q     <= 1'b0;
      out_last_q <= 1'b0;
`endif
    end else begin
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      ptr_q      <= ptr_d;
`ifdef MUX8WAY16_BURST_LOCK_EN
      lock_q     <= lock_d;
      out_last_q <= out_last_d;
`endif
    end
  end

  assign bus.in_ready  = grant_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = (state_q == ST_FULL);
`ifdef MUX8WAY16_BURST_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif

endmodule
